// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select or round-robin arbitration.
// One word per cycle is forwarded into a single output register, with valid/ready on both sides.
`timescale 1ns/1ps
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_chan,
    output logic [CNT_W-1:0]      xfer_count
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_chan_q,  out_chan_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic                 load_en;
    logic                 gnt_any;
    logic [SEL_W-1:0]     gnt_idx;

    assign load_en = !out_valid_q || out_ready;

    // Grant search; round-robin starts one past the last granted channel.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (load_en) begin
            if (!mode) begin
                if (32'(sel) < 32'(N_CH) && in_valid[sel]) begin
                    gnt_any = 1'b1;
                    gnt_idx = sel;
                end
            end else begin
                for (int unsigned off = 1; off <= 32'(N_CH); off++) begin
                    idx = (32'(rr_ptr_q) + off) % 32'(N_CH);
                    if (!gnt_any && in_valid[SEL_W'(idx)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SEL_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (gnt_any) begin
                in_ready[gnt_idx] = 1'b1;
                out_valid_d       = 1'b1;
                out_data_d        = in_data[gnt_idx*WIDTH +: WIDTH];
                out_chan_d        = gnt_idx;
                count_d           = count_q + 1'b1;
                if (mode) begin
                    rr_ptr_d = gnt_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            count_q     <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr: fixed select, round-robin, backpressure, reset.
`timescale 1ns/1ps
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_chan;
    logic [15:0] xfer_count;

    int errors = 0;
    int checks = 0;

    logic [3:0] dat [4];

    stream_mux_rr #(.WIDTH(4), .N_CH(4), .SEL_W(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dat[0] = 4'h7; dat[1] = 4'h5; dat[2] = 4'hA; dat[3] = 4'h3;
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000;
        in_data = {dat[3], dat[2], dat[1], dat[0]};
        out_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'b0000);

        // Fixed select of channel 2
        rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'b0100);
        step();
        chk("fix_out_valid", 32'(out_valid), 32'd1);
        chk("fix_out_data", 32'(out_data), 32'hA);
        chk("fix_out_chan", 32'(out_chan), 32'd2);
        chk("fix_count", 32'(xfer_count), 32'd1);

        // Round-robin, all valid: pointer still at 3 from reset, so ch0 first
        mode = 1'b1;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_all_chan", 32'(out_chan), 32'(i % 4));
            chk("rr_all_data", 32'(out_data), 32'(dat[i % 4]));
        end
        chk("rr_all_count", 32'(xfer_count), 32'd9);

        // Round-robin with only ch1/ch3 valid
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_sparse_ready", 32'(in_ready), (i % 2 == 0) ? 32'b0010 : 32'b1000);
            step();
            chk("rr_sparse_chan", 32'(out_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        chk("rr_sparse_count", 32'(xfer_count), 32'd13);

        // Backpressure: output frozen on ch3 word
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'b0000);
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h3);
            chk("bp_out_chan", 32'(out_chan), 32'd3);
            chk("bp_count", 32'(xfer_count), 32'd13);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0010);
        step();
        chk("bp_release_chan", 32'(out_chan), 32'd1);
        chk("bp_release_data", 32'(out_data), 32'h5);
        chk("bp_release_count", 32'(xfer_count), 32'd14);

        // Reset mid-stream with a word held
        rst = 1'b1; in_valid = 4'b1111;
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(xfer_count), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        step();
        chk("post_rst_chan", 32'(out_chan), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'h7);
        chk("post_rst_count", 32'(xfer_count), 32'd1);

        // No valid inputs: output drains, data/chan hold
        in_valid = 4'b0000;
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_data", 32'(out_data), 32'h7);
        chk("idle_out_chan", 32'(out_chan), 32'd0);
        chk("idle_count", 32'(xfer_count), 32'd1);

        // Fixed mode with selected channel not valid: no grant
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1110;
        #1;
        chk("fix_novalid_ready", 32'(in_ready), 32'b0000);
        step();
        chk("fix_novalid_out_valid", 32'(out_valid), 32'd0);
        chk("fix_novalid_count", 32'(xfer_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
